// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter and 3-state sequencer in front of a single-port synchronous memory.
// Optional MEM_ARB_FIXED_PRIO_EN: on a tie port 1 always wins instead of round-robin.
module mem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 12,
   parameter int MEM_SIZE = 4096
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req_i,
   input  logic [1:0]          we_i,
   input  logic [2*ADDR_W-1:0] addr_i,
   input  logic [2*DATA_W-1:0] wdata_i,
   output logic [1:0]          gnt_o,
   output logic [1:0]          done_o,
   output logic                err_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic                mem_we_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic [DATA_W-1:0]   mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   // One extra bit so MEM_SIZE == 2**ADDR_W compares correctly.
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_SIZE);

   state_e              state_q, state_d;
   logic                win_q, win_d;
   logic                we_q, we_d;
   logic                oor_q, oor_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          gnt_q, gnt_d;
   logic [1:0]          done_q, done_d;
   logic                err_q, err_d;

   logic                sel;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                sel_we;
   logic                sel_oor;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign sel = req_i[1];
`else
   logic last_gnt_q;

   // Reset to 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_gnt_q <= 1'b1;
      else if (state_q == IDLE && |req_i)
         last_gnt_q <= sel;
   end

   assign sel = (&req_i) ? ~last_gnt_q : req_i[1];
`endif

   assign sel_addr  = sel ? addr_i[ADDR_W +: ADDR_W]  : addr_i[0 +: ADDR_W];
   assign sel_wdata = sel ? wdata_i[DATA_W +: DATA_W] : wdata_i[0 +: DATA_W];
   assign sel_we    = sel ? we_i[1] : we_i[0];
   assign sel_oor   = ({1'b0, sel_addr} >= LIMIT);

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      we_d     = we_q;
      oor_d    = oor_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      mem_we_d = 1'b0;
      gnt_d    = 2'b00;
      done_d   = 2'b00;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_i) begin
               state_d    = ACCESS;
               win_d      = sel;
               we_d       = sel_we;
               oor_d      = sel_oor;
               addr_d     = sel_addr;
               wdata_d    = sel_wdata;
               mem_we_d   = sel_we & ~sel_oor;
               gnt_d[sel] = 1'b1;
            end
         end
         ACCESS: state_d = RESP;
         RESP: begin
            state_d       = IDLE;
            done_d[win_q] = 1'b1;
            err_d         = oor_q;
            if (!we_q && !oor_q)
               rdata_d = mem_rdata_i;
         end
         default: state_d = IDLE;
      endcase
   end

   // mem_we_q is only ever high during ACCESS; async reset kills it at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         win_q    <= 1'b0;
         we_q     <= 1'b0;
         oor_q    <= 1'b0;
         mem_we_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         gnt_q    <= 2'b00;
         done_q   <= 2'b00;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         we_q     <= we_d;
         oor_q    <= oor_d;
         mem_we_q <= mem_we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign rdata_o     = rdata_q;
   assign mem_addr_o  = addr_q;
   assign mem_we_o    = mem_we_q;
   assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory; MEM_SIZE=1337 for range tests.
module tb_mem_arbiter;

   localparam int AW = 12;
   localparam int DW = 12;
   localparam int MS = 1337;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req_i;
   logic [1:0]      we_i;
   logic [2*AW-1:0] addr_i;
   logic [2*DW-1:0] wdata_i;
   logic [1:0]      gnt_o, done_o;
   logic            err_o;
   logic [DW-1:0]   rdata_o;
   logic [AW-1:0]   mem_addr_o;
   logic            mem_we_o;
   logic [DW-1:0]   mem_wdata_o;
   logic [DW-1:0]   mem_rdata;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_SIZE(MS)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
      .rdata_o(rdata_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:4095];
   always @(posedge clk) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      mem_rdata <= mem[mem_addr_o];
   end

   int cyc = 0;
   int we_cnt = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (mem_we_o === 1'b1) we_cnt <= we_cnt + 1;

   int n_chk = 0;
   int n_pass = 0;

   int            acc_s, acc_g, acc_d;
   logic [1:0]    acc_gnt, acc_done;
   logic          acc_err;
   logic [DW-1:0] acc_rdata;

   // Issue one request from port p (called just after a posedge) and wait for its grant and done.
   task automatic access(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_i[p] = 1'b1;
      we_i[p]  = w;
      addr_i[p*AW +: AW]  = a;
      wdata_i[p*DW +: DW] = d;
      acc_s = cyc;
      acc_g = -1;
      acc_d = -1;
      for (int i = 0; i < 10 && acc_g < 0; i++) begin
         @(posedge clk); #1;
         if (gnt_o[p]) begin
            acc_g = cyc;
            acc_gnt = gnt_o;
            req_i[p] = 1'b0;
         end
      end
      if (acc_g < 0) begin
         n_chk++;
         $display("FAIL gnt_timeout port=%0d addr=%h", p, a);
         req_i[p] = 1'b0;
         return;
      end
      for (int i = 0; i < 10 && acc_d < 0; i++) begin
         @(posedge clk); #1;
         if (done_o != 2'b00) begin
            acc_d = cyc;
            acc_done = done_o;
            acc_err = err_o;
            acc_rdata = rdata_o;
         end
      end
      if (acc_d < 0) begin
         n_chk++;
         $display("FAIL done_timeout port=%0d addr=%h", p, a);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_i = 2'b00; we_i = 2'b00; addr_i = '0; wdata_i = '0;
      #1;
      n_chk++;
      if ({gnt_o, done_o, err_o, mem_we_o, rdata_o, mem_addr_o, mem_wdata_o} !== '0)
         $display("FAIL reset_outputs got gnt=%b done=%b err=%b we=%b rd=%h ad=%h wd=%h want all 0",
                  gnt_o, done_o, err_o, mem_we_o, rdata_o, mem_addr_o, mem_wdata_o);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_chk++;
      if ({gnt_o, done_o, err_o, mem_we_o} !== '0)
         $display("FAIL post_reset_idle got gnt=%b done=%b err=%b we=%b want 0", gnt_o, done_o, err_o, mem_we_o);
      else n_pass++;
   endtask

   task automatic test_write();
      int w0;
      w0 = we_cnt;
      access(1, 1'b1, 12'h005, 12'hABC);
      n_chk++; if (acc_gnt !== 2'b10) $display("FAIL wr_gnt got %b want 10", acc_gnt); else n_pass++;
      n_chk++; if (acc_g - acc_s !== 1) $display("FAIL wr_gnt_lat got %0d want 1", acc_g - acc_s); else n_pass++;
      n_chk++; if (we_cnt - w0 !== 1) $display("FAIL wr_we_cycles got %0d want 1", we_cnt - w0); else n_pass++;
      n_chk++; if (acc_done !== 2'b10) $display("FAIL wr_done got %b want 10", acc_done); else n_pass++;
      n_chk++; if (acc_d - acc_g !== 2) $display("FAIL wr_done_lat got %0d want 2", acc_d - acc_g); else n_pass++;
      n_chk++; if (acc_err !== 1'b0) $display("FAIL wr_err got %b want 0", acc_err); else n_pass++;
      n_chk++; if (mem[5] !== 12'hABC) $display("FAIL wr_mem got %h want abc", mem[5]); else n_pass++;
   endtask

   task automatic test_readback();
      int w0;
      w0 = we_cnt;
      access(0, 1'b0, 12'h005, 12'h000);
      n_chk++; if (acc_done !== 2'b01) $display("FAIL rd_done got %b want 01", acc_done); else n_pass++;
      n_chk++; if (acc_rdata !== 12'hABC) $display("FAIL rd_data got %h want abc", acc_rdata); else n_pass++;
      n_chk++; if (acc_err !== 1'b0) $display("FAIL rd_err got %b want 0", acc_err); else n_pass++;
      n_chk++; if (we_cnt !== w0) $display("FAIL rd_no_write got %0d want %0d", we_cnt, w0); else n_pass++;
   endtask

   task automatic test_tie();
      int w, g;
      int expw;
      access(1, 1'b1, 12'h001, 12'h111);
      access(1, 1'b1, 12'h002, 12'h222);
      test_reset();
      we_i = 2'b00;
      addr_i = {12'h002, 12'h001};
      req_i = 2'b11;
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         expw = 1;
`else
         expw = k % 2;
`endif
         g = -1;
         for (int i = 0; i < 10 && g < 0; i++) begin
            @(posedge clk); #1;
            if (gnt_o != 2'b00) g = cyc;
         end
         n_chk++;
         if (g < 0) begin
            $display("FAIL tie_gnt_timeout access=%0d", k);
            break;
         end
         w = gnt_o[1] ? 1 : 0;
         if (gnt_o !== (expw ? 2'b10 : 2'b01)) $display("FAIL tie_order access=%0d got %b want port %0d", k, gnt_o, expw);
         else n_pass++;
         req_i[w] = 1'b0;
         repeat (2) @(posedge clk); #1;
         n_chk++;
         if (done_o !== (w ? 2'b10 : 2'b01) || rdata_o !== (w ? 12'h222 : 12'h111))
            $display("FAIL tie_resp access=%0d got done=%b rd=%h want port %0d data", k, done_o, rdata_o, w);
         else n_pass++;
         if (k == 3) req_i = 2'b00;
         else req_i[w] = 1'b1;
      end
      req_i = 2'b00;
      repeat (4) @(posedge clk); #1;
   endtask

   task automatic test_range();
      int w0;
      logic [DW-1:0] r0, m0;
      w0 = we_cnt;
      access(0, 1'b1, 12'h538, 12'h123);
      n_chk++; if (acc_err !== 1'b0 || we_cnt - w0 !== 1) $display("FAIL rng_in_write got err=%b we=%0d want 0/1", acc_err, we_cnt - w0); else n_pass++;
      n_chk++; if (mem[12'h538] !== 12'h123) $display("FAIL rng_in_mem got %h want 123", mem[12'h538]); else n_pass++;
      w0 = we_cnt;
      m0 = mem[12'h539];
      access(1, 1'b1, 12'h539, 12'h456);
      n_chk++; if (acc_err !== 1'b1) $display("FAIL rng_oor_wr_err got %b want 1", acc_err); else n_pass++;
      n_chk++; if (acc_done !== 2'b10) $display("FAIL rng_oor_wr_done got %b want 10", acc_done); else n_pass++;
      n_chk++; if (we_cnt !== w0 || mem[12'h539] !== m0) $display("FAIL rng_oor_no_write got we=%0d mem=%h want %0d/%h", we_cnt, mem[12'h539], w0, m0); else n_pass++;
      r0 = rdata_o;
      access(0, 1'b0, 12'h539, 12'h000);
      n_chk++; if (acc_err !== 1'b1) $display("FAIL rng_oor_rd_err got %b want 1", acc_err); else n_pass++;
      n_chk++; if (acc_rdata !== r0) $display("FAIL rng_oor_rd_hold got %h want %h", acc_rdata, r0); else n_pass++;
   endtask

   task automatic test_sweep();
      int pg;
      pg = -1;
      for (int a = 0; a < MS; a++) begin
         access(0, 1'b1, AW'(a), DW'(a));
         if (pg >= 0) begin
            n_chk++; if (acc_g - pg !== 3) $display("FAIL sweep_wr_spacing addr=%h got %0d want 3", a, acc_g - pg); else n_pass++;
         end
         pg = acc_g;
         access(0, 1'b0, AW'(a), DW'(0));
         n_chk++; if (acc_g - pg !== 3) $display("FAIL sweep_rd_spacing addr=%h got %0d want 3", a, acc_g - pg); else n_pass++;
         pg = acc_g;
         n_chk++; if (acc_rdata !== DW'(a) || acc_err !== 1'b0) $display("FAIL sweep_rd addr=%h got %h err=%b want %h", a, acc_rdata, acc_err, a); else n_pass++;
      end
   endtask

   task automatic test_reset_midop();
      int dn;
      req_i[0] = 1'b1; we_i[0] = 1'b1;
      addr_i[0 +: AW] = 12'h010; wdata_i[0 +: DW] = 12'h7FF;
      @(posedge clk); #1;
      req_i = 2'b00;
      n_chk++; if (gnt_o !== 2'b01 || mem_we_o !== 1'b1) $display("FAIL mid_access got gnt=%b we=%b want 01/1", gnt_o, mem_we_o); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (mem_we_o !== 1'b0) $display("FAIL mid_we_drop got %b want 0", mem_we_o); else n_pass++;
      n_chk++;
      if ({gnt_o, done_o, err_o, rdata_o, mem_addr_o, mem_wdata_o} !== '0)
         $display("FAIL mid_reset_outputs got gnt=%b done=%b err=%b rd=%h ad=%h wd=%h want 0",
                  gnt_o, done_o, err_o, rdata_o, mem_addr_o, mem_wdata_o);
      else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      dn = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done_o != 2'b00) dn++;
      end
      n_chk++; if (dn !== 0) $display("FAIL mid_no_done got %0d want 0", dn); else n_pass++;
      access(0, 1'b0, 12'h010, 12'h000);
      n_chk++; if (acc_rdata !== 12'h010 || mem[12'h010] !== 12'h010) $display("FAIL mid_prior_value got %h mem=%h want 010", acc_rdata, mem[12'h010]); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_readback();
      test_tie();
      test_range();
      test_sweep();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
